// File: rtl/cmos_dvp_native_video_gen.sv
// cmos_dvp_native_video_gen
//
// Converts an OV5640-style 8-bit DVP capture bus (VSYNC, HREF, D[7:0] on the
// sensor pixel clock) into 16-bit native video with active-video, blanking
// and sync. It also reports the measured frame geometry and flags lines that
// carry an odd number of bytes.
//
// Optional feature macro: CMOS_FRAME_SKIP_EN
//   defined   - after reset, the first SKIP_FRAMES frames are discarded
//               (SKIP state and its frame counter are present)
//   undefined - reset enters WAIT_VS directly and SKIP_FRAMES is ignored
//
// Ports:
//   VID_IN_CLK        in   sensor pixel clock, all logic on the rising edge
//   VID_IN_RST        in   synchronous active-high reset
//   CMOS_VSYNC        in   sensor vertical sync (polarity set by VSYNC_ACTIVE_HIGH)
//   CMOS_HREF         in   sensor line-valid
//   CMOS_D[7:0]       in   sensor byte, high byte of each pixel first
//   VID_ACTIVE_VIDEO  out  one-cycle strobe per 16-bit pixel
//   VID_VBLANK        out  vertical blanking
//   VID_HBLANK        out  horizontal blanking
//   VID_VSYNC         out  vertical sync, active high
//   VID_HSYNC         out  HSYNC_WIDTH-cycle pulse after each line
//   VID_DATA[15:0]    out  pixel {first byte, second byte}
//   LINE_PIXELS       out  pixel count of the last completed line
//   FRAME_LINES       out  line count of the last completed frame
//   ERR_ODD_LINE      out  sticky odd-byte-count line flag, cleared by reset
module cmos_dvp_native_video_gen #(
  parameter int VSYNC_ACTIVE_HIGH = 1,
  parameter int HSYNC_WIDTH       = 4,
  parameter int SKIP_FRAMES       = 10,
  parameter int CNT_WIDTH         = 12
) (
  input  logic                 VID_IN_CLK,
  input  logic                 VID_IN_RST,
  input  logic                 CMOS_VSYNC,
  input  logic                 CMOS_HREF,
  input  logic [7:0]           CMOS_D,
  output logic                 VID_ACTIVE_VIDEO,
  output logic                 VID_VBLANK,
  output logic                 VID_HBLANK,
  output logic                 VID_VSYNC,
  output logic                 VID_HSYNC,
  output logic [15:0]          VID_DATA,
  output logic [CNT_WIDTH-1:0] LINE_PIXELS,
  output logic [CNT_WIDTH-1:0] FRAME_LINES,
  output logic                 ERR_ODD_LINE
);

`ifdef CMOS_FRAME_SKIP_EN
  typedef enum logic [1:0] {
    ST_SKIP    = 2'd0,
    ST_WAIT_VS = 2'd1,
    ST_ACTIVE  = 2'd2
  } state_t;
  localparam state_t ST_RESET = state_t'((SKIP_FRAMES == 0) ? ST_WAIT_VS : ST_SKIP);
  localparam logic [7:0] SKIP_LAST = 8'(SKIP_FRAMES - 1);
`else
  typedef enum logic [0:0] {
    ST_WAIT_VS = 1'b0,
    ST_ACTIVE  = 1'b1
  } state_t;
  localparam state_t ST_RESET = ST_WAIT_VS;
`endif

  localparam logic [7:0] HS_RELOAD = 8'(HSYNC_WIDTH - 1);
  localparam logic       VS_INVERT = (VSYNC_ACTIVE_HIGH == 0);

  function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] v);
    return (v == {CNT_WIDTH{1'b1}}) ? v : v + 1'b1;
  endfunction

  // ---- stage p0: registered sensor pins, vsync normalised to active-high
  logic       vs_p0;
  logic       vs_p1;
  logic       href_p0;
  logic [7:0] d_p0;

  always_ff @(posedge VID_IN_CLK) begin
    d_p0 <= CMOS_D;
    if (VID_IN_RST) begin
      // Treat vsync as already active so a sensor sitting in vsync at
      // reset release does not look like a fresh frame start.
      vs_p0   <= 1'b1;
      vs_p1   <= 1'b1;
      href_p0 <= 1'b0;
    end else begin
      vs_p0   <= CMOS_VSYNC ^ VS_INVERT;
      vs_p1   <= vs_p0;
      href_p0 <= CMOS_HREF;
    end
  end

  state_t state;
  state_t state_next;
  logic   active;
  logic   vs_rise;
  logic   line_act;
  logic   line_open;
  logic   line_end;
  logic   phase;
  logic   emit;
  logic [7:0] hi_byte;

  assign active   = (state == ST_ACTIVE);
  assign vs_rise  = vs_p0 & ~vs_p1;
  // Bytes presented while vsync is active are never part of a line.
  assign line_act = active & href_p0 & ~vs_p0;
  // A line ends when it stops being accepted, either at HREF fall or
  // because vsync rose underneath it.
  assign line_end = line_open & ~line_act;
  assign emit     = line_act & phase;

`ifdef CMOS_FRAME_SKIP_EN
  logic [7:0] skip_cnt;

  always_ff @(posedge VID_IN_CLK) begin
    if (VID_IN_RST) begin
      skip_cnt <= '0;
    end else if (state == ST_SKIP && vs_rise) begin
      skip_cnt <= skip_cnt + 1'b1;
    end
  end
`endif

  always_ff @(posedge VID_IN_CLK) begin
    if (VID_IN_RST) begin
      state <= ST_RESET;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
`ifdef CMOS_FRAME_SKIP_EN
      ST_SKIP: begin
        if (vs_rise && skip_cnt == SKIP_LAST) begin
          state_next = ST_WAIT_VS;
        end
      end
`endif
      ST_WAIT_VS: begin
        if (vs_rise) begin
          state_next = ST_ACTIVE;
        end
      end
      ST_ACTIVE: begin
        state_next = ST_ACTIVE;
      end
      default: begin
        state_next = ST_RESET;
      end
    endcase
  end

  // Byte phase restarts on every line so each line begins on a high byte.
  always_ff @(posedge VID_IN_CLK) begin
    if (VID_IN_RST) begin
      phase     <= 1'b0;
      line_open <= 1'b0;
    end else begin
      phase     <= line_act ? ~phase : 1'b0;
      line_open <= line_act;
    end
  end

  always_ff @(posedge VID_IN_CLK) begin
    if (line_act && !phase) begin
      hi_byte <= d_p0;
    end
  end

  // ---- stage p1: registered video outputs and geometry measurement
  logic                 vld_p1;
  logic [15:0]          data_p1;
  logic                 hblank_p1;
  logic                 vblank_p1;
  logic                 vsync_p1;
  logic                 hsync_p1;
  logic [7:0]           hs_cnt;
  logic [CNT_WIDTH-1:0] pix_cnt;
  logic [CNT_WIDTH-1:0] line_cnt;
  logic [CNT_WIDTH-1:0] line_pixels_p1;
  logic [CNT_WIDTH-1:0] frame_lines_p1;
  logic                 err_p1;

  always_ff @(posedge VID_IN_CLK) begin
    if (VID_IN_RST) begin
      vld_p1         <= 1'b0;
      data_p1        <= '0;
      hblank_p1      <= 1'b1;
      vblank_p1      <= 1'b1;
      vsync_p1       <= 1'b0;
      hsync_p1       <= 1'b0;
      hs_cnt         <= '0;
      pix_cnt        <= '0;
      line_cnt       <= '0;
      line_pixels_p1 <= '0;
      frame_lines_p1 <= '0;
      err_p1         <= 1'b0;
    end else begin
      vld_p1 <= emit;
      if (emit) begin
        data_p1 <= {hi_byte, d_p0};
      end

      // Using the next state lets the vsync that opens the first output
      // frame appear on VID_VSYNC.
      vsync_p1 <= vs_p0 & (state_next == ST_ACTIVE);

      if (!active) begin
        hblank_p1 <= 1'b1;
        vblank_p1 <= 1'b1;
      end else begin
        if (emit) begin
          hblank_p1 <= 1'b0;
        end else if (line_end) begin
          hblank_p1 <= 1'b1;
        end
        if (vs_rise) begin
          vblank_p1 <= 1'b1;
        end else if (emit) begin
          vblank_p1 <= 1'b0;
        end
      end

      // A line end during a running pulse reloads the count, so the pulse
      // is stretched rather than cut short.
      if (line_end) begin
        hsync_p1 <= 1'b1;
        hs_cnt   <= HS_RELOAD;
      end else if (hs_cnt != 8'd0) begin
        hsync_p1 <= 1'b1;
        hs_cnt   <= hs_cnt - 1'b1;
      end else begin
        hsync_p1 <= 1'b0;
      end

      if (emit) begin
        pix_cnt <= sat_inc(pix_cnt);
      end else if (line_end) begin
        pix_cnt <= '0;
      end

      if (line_end) begin
        line_pixels_p1 <= pix_cnt;
        // Phase still set at line end means the final byte had no partner.
        if (phase) begin
          err_p1 <= 1'b1;
        end
      end

      // The edge that moves WAIT_VS to ACTIVE has no measured frame behind
      // it, so only edges seen while already active report a line count.
      if (vs_rise) begin
        if (active) begin
          frame_lines_p1 <= line_end ? sat_inc(line_cnt) : line_cnt;
        end
        line_cnt <= '0;
      end else if (line_end) begin
        line_cnt <= sat_inc(line_cnt);
      end
    end
  end

  assign VID_ACTIVE_VIDEO = vld_p1;
  assign VID_DATA         = data_p1;
  assign VID_HBLANK       = hblank_p1;
  assign VID_VBLANK       = vblank_p1;
  assign VID_VSYNC        = vsync_p1;
  assign VID_HSYNC        = hsync_p1;
  assign LINE_PIXELS      = line_pixels_p1;
  assign FRAME_LINES      = frame_lines_p1;
  assign ERR_ODD_LINE     = err_p1;

endmodule
